rr_mux_arbiter: RTL and testbench

//   Round-robin arbiter that shares one mux_4_1 output channel between 4 requesters.

---
 rtl/rr_mux_arbiter_pkg.sv | 17 +
 rtl/rr_mux_arbiter_if.sv | 24 ++
 rtl/mux_4_1.sv | 8 +
 rtl/rr_mux_arbiter_pick.sv | 38 +++
 rtl/rr_mux_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 161 ++++++++++++++++
 6 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side bus of the arbiter: request/data in, grant/select/output back.
interface rr_mux_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             out;
    logic             out_valid;

    // Arbiter side
    modport slave (
        input  req, data,
        output gnt, sel, busy, out, out_valid
    );

    // Requester / test side
    modport master (
        output req, data,
        input  gnt, sel, busy, out, out_valid
    );
endinterface

// File: rtl/mux_4_1.sv
// Plain 4:1 bit multiplexer shared by the requesters.
module mux_4_1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);
    assign y = d[sel];
endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin pick: first set bit of (req & ~mask), searching
// upward from ptr and wrapping 3 -> 0.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [SEL_W-1:0] idx,
    output logic             any
);
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] offset;

    assign masked = req & ~mask;

    // Rotate so that bit 0 of rot is the requester at ptr; index arithmetic
    // is SEL_W bits wide, so it wraps naturally.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = masked[SEL_W'(gi) + ptr];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the nearest requester after ptr.
    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign any = |rot;
    assign idx = ptr + offset;
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one mux_4_1 channel among four requesters.
// Grant is held until released, or preempted after MAX_HOLD cycles when
// another requester is waiting. The selected data bit is registered to out.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic [SEL_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             mux_y;
    logic             cur_req;

    // While idle the search starts at ptr; during a grant it starts just past
    // the current owner and excludes it, so a preempted owner cannot win again.
    assign pick_ptr  = (state_q == GRANT) ? (sel_q + 2'd1) : ptr_q;
    assign pick_mask = (state_q == GRANT) ? onehot(sel_q) : '0;

    rr_pick u_pick (
        .req  (bus.req),
        .ptr  (pick_ptr),
        .mask (pick_mask),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    mux_4_1 u_mux (
        .d   (bus.data),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign cur_req = bus.req[sel_q];

    // Next-state logic: grant, hand over, hold or drop back to idle.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    sel_d      = pick_idx;
                    gnt_d      = onehot(pick_idx);
                    hold_cnt_d = HOLD_ONE;
                end
            end
            GRANT: begin
                if (!cur_req || (hold_cnt_q == HOLD_MAX && pick_any)) begin
                    // Release or preemption: advance priority past the owner.
                    ptr_d = sel_q + 2'd1;
                    if (pick_any) begin
                        sel_d      = pick_idx;
                        gnt_d      = onehot(pick_idx);
                        hold_cnt_d = HOLD_ONE;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output channel: capture the muxed bit only while the owner still requests.
    always_comb begin
        out_valid_d = (state_q == GRANT) && cur_req;
        out_d       = out_valid_d ? mux_y : out_q;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GRANT);
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: vector table on a MAX_HOLD=8 instance, plus
// hand sequences for saturation, fairness (MAX_HOLD=2) and async reset.
module tb_rr_mux_arbiter;
    import arb_pkg::*;

    typedef struct {
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       out;
        logic       ov;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_mux_arbiter_if bus_a ();
    rr_mux_arbiter_if bus_b ();

    rr_mux_arbiter #(.MAX_HOLD(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    rr_mux_arbiter #(.MAX_HOLD(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t exp_q[$];
    vec_t tbl[16];

    task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", name, idx, got, want);
        end
    endtask

    // Drive one vector on instance A, push its expectation, compare after the edge.
    task automatic apply_a(input vec_t v, input int idx);
        vec_t e;
        bus_a.req  = v.req;
        bus_a.data = v.data;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gnt",  idx, bus_a.gnt, e.gnt);
        check("sel",  idx, {2'b00, bus_a.sel}, {2'b00, e.sel});
        check("busy", idx, {3'b000, bus_a.busy}, {3'b000, e.busy});
        check("out",  idx, {3'b000, bus_a.out}, {3'b000, e.out});
        check("ov",   idx, {3'b000, bus_a.out_valid}, {3'b000, e.ov});
        $display("A step=%0d req=%b data=%b gnt=%b sel=%0d busy=%b out=%b ov=%b",
                 idx, v.req, v.data, bus_a.gnt, bus_a.sel, bus_a.busy, bus_a.out, bus_a.out_valid);
    endtask

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] data, input logic [3:0] gnt,
                                input logic [1:0] sel, input logic busy, input logic out, input logic ov);
        vec_t v;
        v.req = req; v.data = data; v.gnt = gnt; v.sel = sel;
        v.busy = busy; v.out = out; v.ov = ov;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_a.req = '0; bus_a.data = '0;
        bus_b.req = '0; bus_b.data = '0;

        //            req      data     gnt      sel    busy  out   ov
        tbl[0]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
        tbl[3]  = mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
        tbl[6]  = mk(4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        tbl[7]  = mk(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
        tbl[8]  = mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mk(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        tbl[10] = mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        tbl[12] = mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
        tbl[14] = mk(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        tbl[15] = mk(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);

        // Reset state, checked while rst_n is still low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",  -1, bus_a.gnt, 4'b0000);
        check("rst_busy", -1, {3'b000, bus_a.busy}, 4'b0000);
        check("rst_ov",   -1, {3'b000, bus_a.out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven main function on instance A.
        for (int i = 0; i < 16; i++) begin
            apply_a(tbl[i], i);
        end

        // Saturation: lone requester 3 keeps the grant well past MAX_HOLD.
        apply_a(mk(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0), 100);
        for (int i = 0; i < 20; i++) begin
            apply_a(mk(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1), 101 + i);
        end
        // Counter is saturated, so a new competitor preempts at the very next edge.
        apply_a(mk(4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1), 121);
        apply_a(mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0), 122);

        // Fairness on instance B (MAX_HOLD=2): each requester holds exactly 2 cycles.
        bus_b.req  = 4'b1111;
        bus_b.data = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            logic [1:0] want_sel;
            logic [3:0] want_gnt;
            want_sel = 2'((k / 2) % 4);
            want_gnt = 4'b0001 << want_sel;
            @(posedge clk);
            #1;
            check("fair_gnt",  200 + k, bus_b.gnt, want_gnt);
            check("fair_busy", 200 + k, {3'b000, bus_b.busy}, 4'b0001);
            $display("B step=%0d gnt=%b sel=%0d busy=%b", 200 + k, bus_b.gnt, bus_b.sel, bus_b.busy);
        end
        bus_b.req = 4'b0000;

        // Asynchronous reset mid-grant: instance A currently holds gnt=0100.
        check("pre_rst_gnt", 300, bus_a.gnt, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("arst_gnt",  301, bus_a.gnt, 4'b0000);
        check("arst_sel",  301, {2'b00, bus_a.sel}, 4'b0000);
        check("arst_busy", 301, {3'b000, bus_a.busy}, 4'b0000);
        check("arst_ov",   301, {3'b000, bus_a.out_valid}, 4'b0000);
        check("arst_out",  301, {3'b000, bus_a.out}, 4'b0000);
        $display("A step=301 async reset gnt=%b sel=%0d busy=%b ov=%b",
                 bus_a.gnt, bus_a.sel, bus_a.busy, bus_a.out_valid);
        bus_a.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
